// File: rtl/hazard_scoreboard.sv
// Decode-side hazard scoreboard: per-register pending countdowns for load/syscall results,
// load-use stall detection, qualified external stall and a saturating stall-cycle counter.
module hazard_scoreboard #(
   parameter int REG_BITS     = 4,
   parameter int NUM_SRC      = 3,
   parameter int LOAD_LATENCY = 1,
   parameter int CNT_BITS     = 16
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         issue_valid,
   input  logic                         regmask,
   input  logic [4:0]                   opcode,
   input  logic [REG_BITS-1:0]          dest_reg,
   input  logic [NUM_SRC*REG_BITS-1:0]  src_regs,
   input  logic [NUM_SRC-1:0]           src_valid,
   input  logic                         external_stall,
   output logic                         stall,
   output logic                         hazard_stall,
   output logic                         ext_stall,
   output logic [CNT_BITS-1:0]          stall_count
);
   localparam int NREGS = 2**REG_BITS;
   localparam logic [2:0] LAT = 3'(LOAD_LATENCY);

   logic [NREGS-1:0][2:0] pend;
   logic                  prevTwoWord;
   logic                  prevExt;
   logic                  isLwn, isLdw, isSyscall, isLdi, isLdl;
   logic                  stallable, twoWord;
   logic [NUM_SRC-1:0]    srcHit;

   assign isLwn     = (opcode[4:1] == 4'b1110);
   assign isLdw     = (opcode[4:1] == 4'b1100);
   assign isSyscall = (opcode == 5'b01000);
   assign isLdi     = (opcode == 5'b00101);
   assign isLdl     = (opcode == 5'b01001);

   assign stallable = issue_valid & ~regmask & (isLwn | isLdw | isSyscall);
   assign twoWord   = issue_valid & ~regmask & (isLdi | isLdl);

   // Sources look at the registered countdowns, so an instruction never hazards on its own dest.
   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : gSrc
      assign srcHit[gi] = src_valid[gi] & (pend[src_regs[gi*REG_BITS +: REG_BITS]] != 3'd0);
   end

   assign hazard_stall = |srcHit;
   // The second word of a two-word immediate is shielded from a freshly raised external stall.
   assign ext_stall    = external_stall & (~prevTwoWord | prevExt);
   assign stall        = hazard_stall | ext_stall;

   always_ff @(posedge clock) begin
      if (reset) begin
         pend        <= '0;
         prevTwoWord <= 1'b0;
         prevExt     <= 1'b0;
         stall_count <= '0;
      end else begin
         if (!ext_stall) begin
            for (int r = 0; r < NREGS; r++) begin
               if (stallable && !stall && dest_reg == REG_BITS'(r))
                  pend[r] <= LAT;
               else if (pend[r] != 3'd0)
                  pend[r] <= pend[r] - 3'd1;
            end
         end
         prevTwoWord <= twoWord & ~stall & ~prevTwoWord;
         prevExt     <= external_stall;
         if (stall && stall_count != '1)
            stall_count <= stall_count + CNT_BITS'(1);
      end
   end
endmodule
